// File: rtl/vx_commit_arbiter_pkg.sv
// Shared constants and types for the commit arbiter: packet framing bits,
// arbiter FSM states and a select-width helper.
package vx_commit_arbiter_pkg;

  localparam int unsigned CommitSopBit = 1;
  localparam int unsigned CommitEopBit = 0;

  typedef enum logic [0:0] {
    ArbIdle,
    ArbLocked
  } arb_state_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_commit_arbiter_skid_buf.sv
// Two-entry FIFO between the arbiter and the commit output. The full flag is
// registered so upstream ready never depends combinationally on ready_i.
module vx_commit_arbiter_skid_buf #(
  parameter int unsigned Width = 66
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  input  logic             ready_i
);

  logic [1:0][Width-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  full_q, full_d;
  logic                  pop;

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign pop     = valid_o & ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push_i) - 2'(pop);
    full_d  = (count_d == 2'd2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Round-robin commit arbiter: grants one execution unit at a time, holds the
// grant across sop..eop packet runs, buffers output and counts stall cycles.
module vx_commit_arbiter
  import vx_commit_arbiter_pkg::*;
#(
  parameter int unsigned NumReqs     = 4,
  parameter int unsigned DataW       = 64,
  parameter int unsigned PerfCtrBits = 44,
  localparam int unsigned SelW       = sel_width(NumReqs)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NumReqs-1:0]              commit_in_valid,
  input  logic [NumReqs-1:0][DataW-1:0]   commit_in_data,
  output logic [NumReqs-1:0]              commit_in_ready,
  output logic                            commit_out_valid,
  output logic [DataW-1:0]                commit_out_data,
  input  logic                            commit_out_ready,
  output logic [SelW-1:0]                 commit_out_sel,
  output logic [PerfCtrBits-1:0]          perf_stalls
);

  arb_state_e             state_q, state_d;
  logic [SelW-1:0]        lock_idx_q, lock_idx_d;
  logic [SelW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PerfCtrBits-1:0] perf_q, perf_d;

  logic [SelW-1:0]        grant;
  logic [SelW-1:0]        idx_sel;
  logic                   grant_valid;
  logic                   buf_full;
  logic                   accept;
  logic [DataW-1:0]       gdata;
  logic                   sop, eop;
  logic                   stall;

  // Grant selection: locked requester only, else first valid after rr_ptr.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx_sel     = '0;
    if (state_q == ArbLocked) begin
      grant       = lock_idx_q;
      grant_valid = commit_in_valid[lock_idx_q];
    end else begin
      for (int unsigned i = 1; i <= NumReqs; i++) begin
        idx_sel = SelW'((32'(rr_ptr_q) + i) % NumReqs);
        if (!grant_valid && commit_in_valid[idx_sel]) begin
          grant_valid = 1'b1;
          grant       = idx_sel;
        end
      end
    end
  end

  assign accept          = grant_valid & ~buf_full & ~reset;
  assign commit_in_ready = accept ? (NumReqs'(1) << grant) : '0;
  assign gdata           = commit_in_data[grant];
  assign sop             = gdata[CommitSopBit];
  assign eop             = gdata[CommitEopBit];
  assign stall           = (|commit_in_valid) & ~(|(commit_in_valid & commit_in_ready));

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = grant;
      unique case (state_q)
        ArbIdle: begin
          // A packet without sop in idle is treated as a single-packet commit.
          if (sop && !eop) begin
            state_d    = ArbLocked;
            lock_idx_d = grant;
          end
        end
        ArbLocked: begin
          if (eop) begin
            state_d = ArbIdle;
          end
        end
        default: state_d = ArbIdle;
      endcase
    end
    perf_d = (stall && (perf_q != '1)) ? perf_q + PerfCtrBits'(1) : perf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ArbIdle;
      lock_idx_q <= '0;
      rr_ptr_q   <= SelW'(NumReqs - 1);
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      perf_q     <= perf_d;
    end
  end

  assign perf_stalls = perf_q;

  vx_commit_arbiter_skid_buf #(
    .Width (DataW + SelW)
  ) u_skid_buf (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (accept),
    .data_i  ({grant, gdata}),
    .full_o  (buf_full),
    .valid_o (commit_out_valid),
    .data_o  ({commit_out_sel, commit_out_data}),
    .ready_i (commit_out_ready)
  );

`ifndef SYNTHESIS
  sop_in_idle_a : assert property (@(posedge clk) disable iff (reset)
    (accept && (state_q == ArbIdle)) |-> sop)
    else $error("commit packet without sop accepted while idle");
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Scoreboard bench for vx_commit_arbiter: random per-requester packet streams,
// a queue-based reference of the arbitration rules, and a perf saturation check.
module tb_vx_commit_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;

  typedef struct packed {
    logic [1:0]    sel;
    logic [DW-1:0] data;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0]          in_valid;
  logic [NR-1:0][DW-1:0]  in_data;
  logic [NR-1:0]          in_ready;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic                   out_ready;
  logic [1:0]             out_sel;
  logic [43:0]            perf;

  logic                   reset2;
  logic [NR-1:0]          v2;
  logic [NR-1:0][DW-1:0]  d2;
  logic [NR-1:0]          r2;
  logic                   ov2;
  logic [DW-1:0]          od2;
  logic                   ordy2;
  logic [1:0]             os2;
  logic [2:0]             p2;

  int          checks   = 0;
  int          failures = 0;
  int unsigned vprob;
  int unsigned rprob;
  logic [DW-1:0] pend[NR][$];
  exp_t        exp_q[$];
  int          m_last;
  int          m_lock;
  int          occ;
  logic [43:0] m_perf;

  vx_commit_arbiter #(
    .NumReqs     (NR),
    .DataW       (DW),
    .PerfCtrBits (44)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .commit_in_valid  (in_valid),
    .commit_in_data   (in_data),
    .commit_in_ready  (in_ready),
    .commit_out_valid (out_valid),
    .commit_out_data  (out_data),
    .commit_out_ready (out_ready),
    .commit_out_sel   (out_sel),
    .perf_stalls      (perf)
  );

  vx_commit_arbiter #(
    .NumReqs     (NR),
    .DataW       (DW),
    .PerfCtrBits (3)
  ) dut_sat (
    .clk              (clk),
    .reset            (reset2),
    .commit_in_valid  (v2),
    .commit_in_data   (d2),
    .commit_in_ready  (r2),
    .commit_out_valid (ov2),
    .commit_out_data  (od2),
    .commit_out_ready (ordy2),
    .commit_out_sel   (os2),
    .perf_stalls      (p2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_txn(input int r, input int len);
    for (int p = 0; p < len; p++) begin
      logic [DW-1:0] d;
      d    = {$urandom, $urandom};
      d[1] = (p == 0);
      d[0] = (p == len - 1);
      pend[r].push_back(d);
    end
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #2;
      done = (in_valid == '0) && (occ == 0);
      for (int r = 0; r < NR; r++) if (pend[r].size() != 0) done = 1'b0;
    end
    check(name, 64'(done), 64'd1);
  endtask

  // Stimulus driver: each requester holds valid until accepted.
  always begin : driver
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    out_ready = ($urandom_range(99) < rprob);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) in_valid[i] = 1'b0;
      if (!in_valid[i] && pend[i].size() > 0 && $urandom_range(99) < vprob) begin
        in_data[i]  = pend[i].pop_front();
        in_valid[i] = 1'b1;
      end
    end
  end

  // Reference model: predicts grant, buffer occupancy and stall count.
  always begin : model_checker
    int            g;
    int            idx;
    logic [NR-1:0] er;
    logic [DW-1:0] gd;
    logic          pop;
    @(negedge clk);
    #1;
    if (reset) begin
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sel", 64'(out_sel), 64'd0);
      check("rst_perf", 64'(perf), 64'd0);
      exp_q.delete();
      occ    = 0;
      m_last = NR - 1;
      m_lock = -1;
      m_perf = '0;
    end else begin
      g = -1;
      if (m_lock >= 0) begin
        if (in_valid[m_lock]) g = m_lock;
      end else begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (g < 0 && in_valid[idx]) g = idx;
        end
      end
      er = '0;
      if (g >= 0 && occ < 2) er[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(er));
      check("out_valid", 64'(out_valid), 64'(occ > 0));
      check("perf_stalls", 64'(perf), 64'(m_perf));
      pop = (occ > 0) && out_ready;
      if (er != '0) begin
        gd = in_data[g];
        exp_q.push_back('{sel: 2'(g), data: gd});
        m_last = g;
        if (m_lock < 0 && gd[1] && !gd[0]) m_lock = g;
        else if (m_lock >= 0 && gd[0]) m_lock = -1;
        occ++;
      end else if (in_valid != '0 && m_perf != '1) begin
        m_perf = m_perf + 44'd1;
      end
      if (pop) occ--;
    end
  end

  // Output monitor: pops the scoreboard on every output handshake.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_sel", 64'(out_sel), 64'(e.sel));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    in_valid = '0;
    in_data  = '0;
    out_ready = 1'b1;
    vprob    = 100;
    rprob    = 100;
    reset2   = 1'b1;
    v2       = '0;
    d2       = '0;
    ordy2    = 1'b0;
    m_last   = NR - 1;
    m_lock   = -1;
    occ      = 0;
    m_perf   = '0;

    // Reset held with all requesters valid, then round-robin singles.
    add_txn(0, 1); add_txn(0, 1); add_txn(1, 1); add_txn(2, 1); add_txn(3, 1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #2;
    check("first_grant", 64'(in_ready), 64'b0001);
    drain("drain_rr", 50);

    // Multi-packet run on req1 competing with req0 and req2.
    add_txn(1, 3); add_txn(0, 1); add_txn(2, 1);
    drain("drain_lock", 50);

    // Output back-pressure with everyone valid.
    rprob = 0;
    for (int r = 0; r < NR; r++) begin
      add_txn(r, 1);
      add_txn(r, 1);
    end
    repeat (6) @(posedge clk);
    #2;
    rprob = 100;
    drain("drain_backpressure", 80);

    // Reset pulse while locked on req3.
    add_txn(3, 3);
    for (int c = 0; c < 50 && m_lock != 3; c++) begin
      @(posedge clk);
      #2;
    end
    reset    = 1'b1;
    in_valid = '0;
    for (int r = 0; r < NR; r++) pend[r].delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int r = 0; r < NR; r++) add_txn(r, 1);
    @(posedge clk);
    @(negedge clk);
    #2;
    check("grant_after_lock_reset", 64'(in_ready), 64'b0001);
    drain("drain_after_reset", 50);

    // Randomized traffic.
    rprob = 70;
    for (int t = 0; t < 60; t++) begin
      for (int r = 0; r < NR; r++) begin
        if ($urandom_range(3) == 0) add_txn(r, int'($urandom_range(1, 4)));
      end
      vprob = $urandom_range(30, 100);
      repeat (20) @(posedge clk);
    end
    #2;
    rprob = 100;
    vprob = 100;
    drain("drain_random", 2000);

    // Narrow counter saturation on the second instance.
    @(posedge clk);
    #2;
    reset2 = 1'b0;
    d2[0]  = 64'h3;
    v2     = 4'b0001;
    repeat (8) @(posedge clk);
    #2;
    check("sat_perf_mid", 64'(p2), 64'd6);
    repeat (4) @(posedge clk);
    #2;
    check("sat_perf_full", 64'(p2), 64'd7);
    repeat (5) @(posedge clk);
    #2;
    check("sat_perf_hold", 64'(p2), 64'd7);
    check("sat_in_ready", 64'(r2), 64'd0);
    check("sat_out_valid", 64'(ov2), 64'd1);
    check("sat_out_data", od2, 64'h3);
    check("sat_out_sel", 64'(os2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
